// File: rtl/parallel_serial_capture.sv
// Eight-lane serial-to-parallel capture: a start edge samples every lane NDATA
// times on a divided tick, then the 8 lane words are pushed into a small FIFO.

module psc_lane #(
  parameter int NDATA = 10
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             mode_i,
  input  logic             fd_i,
  output logic [NDATA-1:0] data_o
);
  logic [NDATA-1:0] sr_q, sr_d;

  generate
    if (NDATA == 1) begin : g_one
      always_comb sr_d = tick_i ? fd_i : sr_q;
    end else begin : g_many
      // mode=1 walks the first sample up to the MSB; mode=0 walks it down to bit 0
      always_comb begin
        sr_d = sr_q;
        if (tick_i) sr_d = mode_i ? {sr_q[NDATA-2:0], fd_i} : {fd_i, sr_q[NDATA-1:1]};
      end
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst)
    if (!rst) sr_q <= '0;
    else      sr_q <= sr_d;

  assign data_o = sr_q;
endmodule

module parallel_serial_capture #(
  parameter int NDATA      = 10,
  parameter int FIFO_WIDTH = 36,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  start_pulse,
  input  logic                  fd0,
  input  logic                  fd1,
  input  logic                  fd2,
  input  logic                  fd3,
  input  logic                  fd4,
  input  logic                  fd5,
  input  logic                  fd6,
  input  logic                  fd7,
  input  logic                  mode,
  input  logic                  fifo_rd_en,
  output logic                  fifo_empty,
  output logic [FIFO_WIDTH-1:0] fifo_q
);
  localparam int NUM_LANES = 8;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(NDATA + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NDATA - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;

  state_t                            state_q, state_d;
  logic [DW-1:0]                     div_q, div_d;
  logic [BW-1:0]                     bcnt_q, bcnt_d;
  logic [2:0]                        lane_q, lane_d;
  logic                              par_q, par_d;
  logic                              start_pulse_q;
  logic                              start, tick, wr_en;
  logic [NUM_LANES-1:0]              fd_bus;
  logic [NUM_LANES-1:0][NDATA-1:0]   lane_data;

  assign start  = start_pulse & ~start_pulse_q;
  assign fd_bus = {fd7, fd6, fd5, fd4, fd3, fd2, fd1, fd0};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      psc_lane #(.NDATA(NDATA)) u_lane (
        .clk_in (clk_in),
        .rst    (rst),
        .tick_i (tick),
        .mode_i (mode),
        .fd_i   (fd_bus[gi]),
        .data_o (lane_data[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bcnt_d  = bcnt_q;
    lane_d  = lane_q;
    par_d   = par_q;
    tick    = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        div_d   = '0;
        bcnt_d  = '0;
      end
      SHIFT: if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick   = 1'b1;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BIT_LAST) begin
          state_d = WRITE;
          lane_d  = '0;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
      WRITE: begin
        wr_en  = 1'b1;
        lane_d = lane_q + 1'b1;
        if (lane_q == 3'd7) begin
          state_d = IDLE;
          par_d   = ~par_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst)
    if (!rst) begin
      state_q       <= IDLE;
      div_q         <= '0;
      bcnt_q        <= '0;
      lane_q        <= '0;
      par_q         <= 1'b0;
      start_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bcnt_q        <= bcnt_d;
      lane_q        <= lane_d;
      par_q         <= par_d;
      start_pulse_q <= start_pulse;
    end

  // FIFO: extra pointer bit separates full from empty
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wptr_q, rptr_q;
  logic [FIFO_WIDTH-1:0] q_q;
  logic [FIFO_WIDTH-1:0] wdata;
  logic                  full, do_wr, do_rd;

  assign wdata      = {par_q, lane_q, 32'(lane_data[lane_q])};
  assign fifo_empty = (wptr_q == rptr_q);
  assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_wr      = wr_en & ~full;
  assign do_rd      = fifo_rd_en & ~fifo_empty;
  assign fifo_q     = q_q;

  always_ff @(posedge clk_in)
    if (do_wr) mem[wptr_q[AW-1:0]] <= wdata;

  always_ff @(posedge clk_in or negedge rst)
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      q_q    <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) begin
        rptr_q <= rptr_q + 1'b1;
        q_q    <= mem[rptr_q[AW-1:0]];
      end
    end
endmodule

// File: tb/tb_parallel_serial_capture.sv
// Scoreboard bench for parallel_serial_capture (NDATA=10, CLK_DIV=4, FIFO_DEPTH=8).

module tb_parallel_serial_capture;
  localparam int ND = 10;
  localparam int CD = 4;
  localparam int DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst = 1'b0;
  logic        start_pulse = 1'b0;
  logic [7:0]  fd = 8'h00;
  logic        mode = 1'b0;
  logic        fifo_rd_en = 1'b0;
  logic        fifo_empty;
  logic [35:0] fifo_q;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [35:0] sb[$];
  logic        par_m = 1'b0;
  logic [35:0] last_exp = '0;

  always #5 clk_in = ~clk_in;

  parallel_serial_capture #(.NDATA(ND), .FIFO_WIDTH(36), .CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .start_pulse (start_pulse),
    .fd0         (fd[0]),
    .fd1         (fd[1]),
    .fd2         (fd[2]),
    .fd3         (fd[3]),
    .fd4         (fd[4]),
    .fd5         (fd[5]),
    .fd6         (fd[6]),
    .fd7         (fd[7]),
    .mode        (mode),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_empty  (fifo_empty),
    .fifo_q      (fifo_q)
  );

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Lane word from the sample sequence: b0 for ticks 1..ftick, b1 afterwards.
  function automatic logic [31:0] exp_data(input logic b0, input int ftick, input logic b1, input logic md);
    logic [31:0] d;
    logic        b;
    d = '0;
    for (int i = 1; i <= ND; i++) begin
      b = (ftick > 0 && i > ftick) ? b1 : b0;
      if (md) d[ND-i] = b;
      else    d[i-1]  = b;
    end
    return d;
  endfunction

  task automatic run_frame(input logic [7:0] lanes, input int ftick, input logic fval,
                           input logic md, input bit busy, input bit chk_empty);
    logic [2:0] ln;
    logic [31:0] d;
    @(negedge clk_in);
    fd = lanes;
    mode = md;
    start_pulse = 1'b1;
    for (int l = 0; l < 8; l++) begin
      ln = 3'(l);
      d = (l == 3) ? exp_data(lanes[l], ftick, fval, md) : exp_data(lanes[l], 0, 1'b0, md);
      if (sb.size() < DEPTH) sb.push_back({par_m, ln, d});
    end
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk_in);
      if (c == 1) start_pulse = 1'b0;
      if (busy && c == 10) start_pulse = 1'b1;
      if (busy && c == 11) start_pulse = 1'b0;
      if (ftick > 0 && c == ftick * CD + 2) fd[3] = fval;
      if (chk_empty && c == 40) chk("empty_before_write", {35'b0, fifo_empty}, 36'd1);
      if (c == 49) chk("empty_after_write", {35'b0, fifo_empty}, 36'd0);
    end
    par_m = ~par_m;
  endtask

  task automatic drain(input string tag);
    int extra;
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      if (fifo_empty) break;
      fifo_rd_en = 1'b1;
      @(negedge clk_in);
      fifo_rd_en = 1'b0;
      if (sb.size() > 0) begin
        last_exp = sb.pop_front();
        chk(tag, fifo_q, last_exp);
      end else begin
        extra++;
      end
    end
    chk({tag, "_extra"}, 36'(extra), 36'd0);
    chk({tag, "_missing"}, 36'(sb.size()), 36'd0);
    chk({tag, "_empty"}, {35'b0, fifo_empty}, 36'd1);
    sb.delete();
  endtask

  initial begin
    int saw_wr;
    // reset state
    repeat (3) @(negedge clk_in);
    chk("rst_empty", {35'b0, fifo_empty}, 36'd1);
    chk("rst_q", fifo_q, 36'd0);
    rst = 1'b1;
    saw_wr = 0;
    repeat (1000) begin
      @(negedge clk_in);
      if (!fifo_empty) saw_wr++;
    end
    chk("idle_no_write", 36'(saw_wr), 36'd0);

    // constant lanes, mode=1
    run_frame(8'hBF, 0, 1'b0, 1'b1, 0, 1);
    drain("const_m1");

    // fd3 falls after the 3rd tick, both bit orders
    run_frame(8'hBF, 3, 1'b0, 1'b1, 0, 1);
    drain("edge_m1");
    run_frame(8'hBF, 3, 1'b0, 1'b0, 0, 1);
    drain("edge_m0");

    // read while empty holds fifo_q
    fifo_rd_en = 1'b1;
    repeat (2) @(negedge clk_in);
    fifo_rd_en = 1'b0;
    @(negedge clk_in);
    chk("rd_empty_hold", fifo_q, last_exp);
    chk("rd_empty_flag", {35'b0, fifo_empty}, 36'd1);

    // second start while busy is ignored, then a fresh frame
    run_frame(8'h3C, 0, 1'b0, 1'b0, 1, 1);
    drain("busy");
    run_frame(8'hC3, 0, 1'b0, 1'b1, 0, 1);
    drain("second");

    // overflow: two frames, no reads; second frame dropped
    run_frame(8'h5A, 0, 1'b0, 1'b0, 0, 1);
    run_frame(8'hA5, 0, 1'b0, 1'b1, 0, 0);
    drain("overflow");

    // async reset mid-SHIFT aborts the frame
    @(negedge clk_in);
    fd = 8'hFF;
    start_pulse = 1'b1;
    @(negedge clk_in);
    start_pulse = 1'b0;
    repeat (20) @(negedge clk_in);
    #2 rst = 1'b0;
    #1;
    chk("midrst_empty", {35'b0, fifo_empty}, 36'd1);
    chk("midrst_q", fifo_q, 36'd0);
    repeat (3) @(negedge clk_in);
    rst = 1'b1;
    par_m = 1'b0;
    sb.delete();
    repeat (60) @(negedge clk_in);
    chk("midrst_no_write", {35'b0, fifo_empty}, 36'd1);
    run_frame(8'h96, 0, 1'b0, 1'b1, 0, 1);
    drain("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
